biriscv_fetch_queue: RTL and testbench



---
 rtl/biriscv_fetch_queue_if.sv | 63 ++++++
 rtl/biriscv_fetch_queue.sv | 143 ++++++++++++++
 tb/tb_biriscv_fetch_queue.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_fetch_queue_if.sv
// biriscv_fetch_queue_if: frontend-to-issue handshake bundle for the fetch queue.
// Two decoded input slots, two oldest output slots, plus occupancy level.
interface biriscv_fetch_queue_if #(
    parameter int DEPTH_W = 3
);
    logic               flush_i;

    logic               in0_valid_i;
    logic [31:0]        in0_instr_i;
    logic [31:0]        in0_pc_i;
    logic [1:0]         in0_fault_i;
    logic [7:0]         in0_info_i;
    logic               in0_accept_o;

    logic               in1_valid_i;
    logic [31:0]        in1_instr_i;
    logic [31:0]        in1_pc_i;
    logic [1:0]         in1_fault_i;
    logic [7:0]         in1_info_i;
    logic               in1_accept_o;

    logic               out0_valid_o;
    logic [31:0]        out0_instr_o;
    logic [31:0]        out0_pc_o;
    logic [1:0]         out0_fault_o;
    logic [7:0]         out0_info_o;
    logic               out0_accept_i;

    logic               out1_valid_o;
    logic [31:0]        out1_instr_o;
    logic [31:0]        out1_pc_o;
    logic [1:0]         out1_fault_o;
    logic [7:0]         out1_info_o;
    logic               out1_accept_i;

    logic [DEPTH_W:0]   level_o;

    modport slave (
        input  flush_i,
        input  in0_valid_i, in0_instr_i, in0_pc_i, in0_fault_i, in0_info_i,
        output in0_accept_o,
        input  in1_valid_i, in1_instr_i, in1_pc_i, in1_fault_i, in1_info_i,
        output in1_accept_o,
        output out0_valid_o, out0_instr_o, out0_pc_o, out0_fault_o, out0_info_o,
        input  out0_accept_i,
        output out1_valid_o, out1_instr_o, out1_pc_o, out1_fault_o, out1_info_o,
        input  out1_accept_i,
        output level_o
    );

    modport master (
        output flush_i,
        output in0_valid_i, in0_instr_i, in0_pc_i, in0_fault_i, in0_info_i,
        input  in0_accept_o,
        output in1_valid_i, in1_instr_i, in1_pc_i, in1_fault_i, in1_info_i,
        input  in1_accept_o,
        input  out0_valid_o, out0_instr_o, out0_pc_o, out0_fault_o, out0_info_o,
        output out0_accept_i,
        input  out1_valid_o, out1_instr_o, out1_pc_o, out1_fault_o, out1_info_o,
        output out1_accept_i,
        input  level_o
    );
endinterface

// File: rtl/biriscv_fetch_queue.sv
// biriscv_fetch_queue: dual-in / dual-out in-order instruction queue.
// Optional same-cycle bypass when empty: define BIRISCV_FETCHQ_BYPASS_EN.
module biriscv_fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    biriscv_fetch_queue_if.slave  fq
);
    localparam int ENTRY_W = 74;

    localparam logic [DEPTH_W:0] CNT_ONE  = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W:0] CNT_TWO  = (DEPTH_W+1)'(2);
    localparam logic [DEPTH_W:0] CNT_FULL = (DEPTH_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] ram_q [DEPTH];

    logic [DEPTH_W-1:0] wr_ptr_q;
    logic [DEPTH_W-1:0] rd_ptr_q;
    logic [DEPTH_W:0]   count_q;

    logic [DEPTH_W:0]   free_w;
    logic               accept0_w;
    logic               accept1_w;
    logic               push0_w;
    logic               push1_w;
    logic               write0_w;
    logic               write1_w;
    logic [DEPTH_W-1:0] wr_idx1_w;
    logic [DEPTH_W-1:0] rd_idx1_w;

    logic [ENTRY_W-1:0] in0_ent_w;
    logic [ENTRY_W-1:0] in1_ent_w;
    logic [ENTRY_W-1:0] out0_ent_w;
    logic [ENTRY_W-1:0] out1_ent_w;
    logic               out0_vld_w;
    logic               out1_vld_w;

    logic               bypass_w;
    logic               pop0_w;
    logic               pop1_w;
    logic               qpop0_w;
    logic               qpop1_w;

    // Entry packing: {info, fault, pc, instr}
    assign in0_ent_w = {fq.in0_info_i, fq.in0_fault_i, fq.in0_pc_i, fq.in0_instr_i};
    assign in1_ent_w = {fq.in1_info_i, fq.in1_fault_i, fq.in1_pc_i, fq.in1_instr_i};

    // Space is judged from the registered count only, so issue-side
    // accepts never feed back combinationally into frontend accepts.
    assign free_w    = CNT_FULL - count_q;
    assign accept0_w = !fq.flush_i && (free_w >= CNT_ONE);
    assign accept1_w = !fq.flush_i &&
                       (fq.in0_valid_i ? (free_w >= CNT_TWO)
                                       : (free_w >= CNT_ONE));

    assign push0_w = fq.in0_valid_i && accept0_w;
    assign push1_w = fq.in1_valid_i && accept1_w;

    assign fq.in0_accept_o = accept0_w;
    assign fq.in1_accept_o = accept1_w;

`ifdef BIRISCV_FETCHQ_BYPASS_EN
    assign bypass_w = (count_q == '0) && !fq.flush_i;
`else
    assign bypass_w = 1'b0;
`endif

    assign rd_idx1_w = rd_ptr_q + DEPTH_W'(1);

    // Present the two oldest entries; invalid slots drive zero data
    always_comb begin
        out0_vld_w = (count_q >= CNT_ONE);
        out1_vld_w = (count_q >= CNT_TWO);
        out0_ent_w = '0;
        out1_ent_w = '0;
        if (out0_vld_w) begin
            out0_ent_w = ram_q[rd_ptr_q];
        end
        if (out1_vld_w) begin
            out1_ent_w = ram_q[rd_idx1_w];
        end
`ifdef BIRISCV_FETCHQ_BYPASS_EN
        if (bypass_w) begin
            out0_vld_w = fq.in0_valid_i;
            out1_vld_w = fq.in1_valid_i;
            out0_ent_w = fq.in0_valid_i ? in0_ent_w : '0;
            out1_ent_w = fq.in1_valid_i ? in1_ent_w : '0;
        end
`endif
    end

    assign fq.out0_valid_o = out0_vld_w;
    assign fq.out1_valid_o = out1_vld_w;
    assign {fq.out0_info_o, fq.out0_fault_o,
            fq.out0_pc_o, fq.out0_instr_o} = out0_ent_w;
    assign {fq.out1_info_o, fq.out1_fault_o,
            fq.out1_pc_o, fq.out1_instr_o} = out1_ent_w;

    // Issue is in-order: slot 1 only pops together with slot 0
    assign pop0_w = out0_vld_w && fq.out0_accept_i;
    assign pop1_w = pop0_w && out1_vld_w && fq.out1_accept_i;

    // Bypassed slots consumed this cycle never touch storage
    assign qpop0_w  = pop0_w && !bypass_w;
    assign qpop1_w  = pop1_w && !bypass_w;
    assign write0_w = push0_w && !(bypass_w && pop0_w);
    assign write1_w = push1_w && !(bypass_w && pop1_w);

    assign wr_idx1_w = wr_ptr_q + DEPTH_W'(write0_w);

    assign fq.level_o = count_q;

    // Entry storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk_i) begin
        if (write0_w) begin
            ram_q[wr_ptr_q] <= in0_ent_w;
        end
        if (write1_w) begin
            ram_q[wr_idx1_w] <= in1_ent_w;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties in one cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fq.flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_W'(write0_w) + DEPTH_W'(write1_w);
            rd_ptr_q <= rd_ptr_q + DEPTH_W'(qpop0_w) + DEPTH_W'(qpop1_w);
            count_q  <= count_q
                      + (DEPTH_W+1)'(write0_w) + (DEPTH_W+1)'(write1_w)
                      - (DEPTH_W+1)'(qpop0_w)  - (DEPTH_W+1)'(qpop1_w);
        end
    end
endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// tb_biriscv_fetch_queue: directed scoreboard bench for the fetch queue.
// Driver pushes expected entries; negedge monitor checks issue outputs.
module tb_biriscv_fetch_queue;
    localparam int DEPTH   = 8;
    localparam int DEPTH_W = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
        logic [7:0]  info;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    biriscv_fetch_queue_if #(.DEPTH_W(DEPTH_W)) fq ();

    biriscv_fetch_queue #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .fq    (fq)
    );

    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mcount = 0;
    int   mvis   = 0;
    int   seq    = 0;

    function automatic ent_t mk(input int n);
        ent_t e;
        logic [31:0] nn;
        nn      = n;
        e.pc    = 32'h8000_0000 + (nn << 2);
        e.instr = 32'h0013_0013 ^ (nn * 32'h0000_9E37);
        e.fault = nn[1:0];
        e.info  = nn[7:0] ^ 8'hA5;
        return e;
    endfunction

    function automatic logic [73:0] pk(input ent_t e);
        return {e.info, e.fault, e.pc, e.instr};
    endfunction

    task automatic chk(input string nm, input logic [73:0] act,
                       input logic [73:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v0, input bit v1, input bit a0,
                         input bit a1, input bit fl);
        ent_t x0;
        ent_t x1;
        x0 = mk(seq);
        x1 = mk(seq + 1);
        fq.flush_i       = fl;
        fq.in0_valid_i   = v0;
        fq.in0_pc_i      = x0.pc;
        fq.in0_instr_i   = x0.instr;
        fq.in0_fault_i   = x0.fault;
        fq.in0_info_i    = x0.info;
        fq.in1_valid_i   = v1;
        fq.in1_pc_i      = x1.pc;
        fq.in1_instr_i   = x1.instr;
        fq.in1_fault_i   = x1.fault;
        fq.in1_info_i    = x1.info;
        fq.out0_accept_i = a0;
        fq.out1_accept_i = a1;
    endtask

    // One clock of stimulus; called just after a rising edge
    task automatic cycle(input bit v0, input bit v1, input bit a0,
                         input bit a1, input bit fl);
        int fr;
        bit e0;
        bit e1;
        int pu;
        int po;
        drive(v0, v1, a0, a1, fl);
        mvis = mcount;
        #1;
        fr = DEPTH - mcount;
        e0 = !fl && (fr >= 1);
        e1 = !fl && (v0 ? (fr >= 2) : (fr >= 1));
        chk("in0_accept", 74'(fq.in0_accept_o), 74'(e0));
        chk("in1_accept", 74'(fq.in1_accept_o), 74'(e1));
        pu = 0;
        if (v0 && e0) begin
            sb.push_back(mk(seq));
            pu++;
        end
        if (v1 && e1) begin
            sb.push_back(mk(seq + 1));
            pu++;
        end
        seq += 2;
        po = 0;
        if (mcount >= 1 && a0) begin
            po++;
            if (mcount >= 2 && a1) po++;
        end
        mcount = fl ? 0 : mcount + pu - po;
        @(posedge clk);
        #1;
        chk("level", 74'(fq.level_o), 74'(mcount));
    endtask

    // Monitor: compare presented entries with scoreboard, retire pops
    always @(negedge clk) begin
        if (rst_n) begin
            bit p0;
            bit p1;
            chk("out0_valid", 74'(fq.out0_valid_o), 74'(mvis >= 1));
            chk("out1_valid", 74'(fq.out1_valid_o), 74'(mvis >= 2));
            if (fq.out0_valid_o) begin
                if (sb.size() >= 1)
                    chk("out0_data",
                        {fq.out0_info_o, fq.out0_fault_o,
                         fq.out0_pc_o, fq.out0_instr_o}, pk(sb[0]));
                else
                    chk("out0_unexpected", 74'(1), 74'(0));
            end else begin
                chk("out0_zero",
                    {fq.out0_info_o, fq.out0_fault_o,
                     fq.out0_pc_o, fq.out0_instr_o}, 74'(0));
            end
            if (fq.out1_valid_o) begin
                if (sb.size() >= 2)
                    chk("out1_data",
                        {fq.out1_info_o, fq.out1_fault_o,
                         fq.out1_pc_o, fq.out1_instr_o}, pk(sb[1]));
                else
                    chk("out1_unexpected", 74'(1), 74'(0));
            end else begin
                chk("out1_zero",
                    {fq.out1_info_o, fq.out1_fault_o,
                     fq.out1_pc_o, fq.out1_instr_o}, 74'(0));
            end
            p0 = (mvis >= 1) && fq.out0_accept_i;
            p1 = p0 && (mvis >= 2) && fq.out1_accept_i;
            if (fq.flush_i) begin
                sb.delete();
            end else begin
                if (p0 && sb.size() > 0) void'(sb.pop_front());
                if (p1 && sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_level", 74'(fq.level_o), 74'(0));
        chk("rst_out0_valid", 74'(fq.out0_valid_o), 74'(0));
        chk("rst_out1_valid", 74'(fq.out1_valid_o), 74'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in0_accept", 74'(fq.in0_accept_o), 74'(1));
        chk("rst_in1_accept", 74'(fq.in1_accept_o), 74'(1));

        // Streaming dual push / dual pop, crossing pointer wrap
        for (int i = 0; i < 12; i++) cycle(1, 1, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);

        // Fill to full, then boundary accepts at 8 and 7
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0);

        // Out-of-order accept on slot 1 alone pops nothing
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);

        // Push/pop while full: pops do not free space this cycle
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 0);

        // Flush at level 6 with both slots valid, then reuse storage
        cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 1, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);

        // Asynchronous reset mid-traffic at level 5
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 74'(fq.level_o), 74'(0));
        chk("mid_rst_out0_valid", 74'(fq.out0_valid_o), 74'(0));
        chk("mid_rst_out1_valid", 74'(fq.out1_valid_o), 74'(0));
        chk("mid_rst_out0_data",
            {fq.out0_info_o, fq.out0_fault_o,
             fq.out0_pc_o, fq.out0_instr_o}, 74'(0));
        mcount = 0;
        mvis   = 0;
        sb.delete();
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in0_accept", 74'(fq.in0_accept_o), 74'(1));
        chk("post_rst_in1_accept", 74'(fq.in1_accept_o), 74'(1));
        @(posedge clk);
        #1;

        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
